tft_ctrl: RTL and testbench

- TFT-LCD timing controller for the 480x272 panel driven from the 9 MHz pixel clock.
- Generates horizontal and vertical counters, hsync/vsync, and data-enable.
- Issues pixel coordinates (pix_x, pix_y) one cycle early to the pixel-generator blocks (char/picture generators), which return registered pix_data.
- Gates the returned pix_data onto the panel RGB bus; it is the consumer end of the pix_x/pix_y -> pix_data interface.

---
 rtl/tft_timing_pkg.sv | 51 +++++
 rtl/tft_axis_cnt.sv | 57 +++++
 rtl/tft_ctrl.sv | 100 ++++++++++
 tb/tb_tft_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_timing_pkg.sv
// Shared timing constants and helpers for the 480x272 TFT panel.
// The pixel generators import the same values so their coordinate space
// matches the timing controller exactly.
package tft_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [9:0] H_SYNC  = 10'd41;
    localparam logic [9:0] H_BACK  = 10'd2;
    localparam logic [9:0] H_VALID = 10'd480;
    localparam logic [9:0] H_FRONT = 10'd2;
    localparam logic [9:0] H_TOTAL = 10'd525;

    // Vertical timing, in lines
    localparam logic [9:0] V_SYNC  = 10'd10;
    localparam logic [9:0] V_BACK  = 10'd2;
    localparam logic [9:0] V_VALID = 10'd272;
    localparam logic [9:0] V_FRONT = 10'd2;
    localparam logic [9:0] V_TOTAL = 10'd286;

    // Active level of hsync/vsync
    localparam logic SYNC_POL = 1'b1;

    // Coordinate value meaning "no pixel requested"
    localparam logic [9:0] NO_PIX = 10'h3ff;

    // RGB565 colour constants
    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hffff;
    localparam logic [15:0] RED     = 16'hf800;
    localparam logic [15:0] GREEN   = 16'h07e0;
    localparam logic [15:0] BLUE    = 16'h001f;
    localparam logic [15:0] YELLOW  = 16'hffe0;
    localparam logic [15:0] CYAN    = 16'h07ff;
    localparam logic [15:0] MAGENTA = 16'hf81f;
    localparam logic [15:0] GRAY    = 16'hd69a;

    // Per-axis window decode produced by tft_axis_cnt
    typedef struct packed {
        logic sync_act;  // counter inside the sync pulse
        logic valid;     // counter inside the active (displayed) window
        logic req;       // counter inside the coordinate-request window
    } axis_win_t;

    // True when cnt lies in the half-open window [lo, lo+len)
    function automatic logic in_window(input logic [9:0] cnt,
                                       input logic [9:0] lo,
                                       input logic [9:0] len);
        return (cnt >= lo) && (cnt < (lo + len));
    endfunction

endpackage

// File: rtl/tft_axis_cnt.sv
// One timing axis: a wrap counter with enable, a wrap flag for cascading,
// and decode of the sync, active and request windows. The request window
// can be moved REQ_LEAD counts earlier than the active window so that a
// registered downstream generator returns data exactly in the active slot.
module tft_axis_cnt
    import tft_timing_pkg::*;
#(
    parameter logic [9:0] TOTAL    = H_TOTAL,
    parameter logic [9:0] SYNC     = H_SYNC,
    parameter logic [9:0] BACK     = H_BACK,
    parameter logic [9:0] VALID    = H_VALID,
    parameter logic [9:0] REQ_LEAD = 10'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap,
    output axis_win_t  win
);

    localparam logic [9:0] ACT_START = SYNC + BACK;
    localparam logic [9:0] REQ_START = ACT_START - REQ_LEAD;

    logic [9:0] cnt_d;
    logic [9:0] cnt_q;
    logic       at_last;

    // Next count: advance when enabled, wrap TOTAL-1 -> 0
    always_comb begin
        at_last = (cnt_q == (TOTAL - 10'd1));
        cnt_d   = cnt_q;
        if (en) begin
            cnt_d = at_last ? 10'd0 : cnt_q + 10'd1;
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 10'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Window decode straight off the registered count
    always_comb begin
        win.sync_act = (cnt_q < SYNC);
        win.valid    = in_window(cnt_q, ACT_START, VALID);
        win.req      = in_window(cnt_q, REQ_START, VALID);
    end

    assign cnt  = cnt_q;
    assign wrap = en & at_last;

endmodule

// File: rtl/tft_ctrl.sv
// TFT-LCD timing controller for a 480x272 panel on the 9 MHz pixel clock.
// Two cascaded axis counters produce hsync/vsync/data-enable; the
// controller also requests pixel coordinates from the generators and
// gates their returned data onto the panel bus.
//
// Generator interface: pix_x/pix_y are presented one cycle before the
// panel slot they belong to. The generator registers its answer, so
// pix_data for coordinate (x,y) requested in cycle n is valid in cycle
// n+1, which is exactly when tft_de is high for that pixel. There is no
// back-pressure; pix_x/pix_y read 10'h3ff when nothing is requested and
// pix_data is ignored whenever tft_de is low.
module tft_ctrl
    import tft_timing_pkg::*;
#(
    parameter logic [9:0] P_H_SYNC   = H_SYNC,
    parameter logic [9:0] P_H_BACK   = H_BACK,
    parameter logic [9:0] P_H_VALID  = H_VALID,
    parameter logic [9:0] P_H_TOTAL  = H_TOTAL,
    parameter logic [9:0] P_V_SYNC   = V_SYNC,
    parameter logic [9:0] P_V_BACK   = V_BACK,
    parameter logic [9:0] P_V_VALID  = V_VALID,
    parameter logic [9:0] P_V_TOTAL  = V_TOTAL,
    parameter logic       P_SYNC_POL = SYNC_POL
) (
    input  logic        clk_9m,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] rgb_tft,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_de,
    output logic        tft_clk,
    output logic        tft_bl,
    output logic        frame_start
);

    // First requested column sits one clock before the first active column
    localparam logic [9:0] X_ORIGIN = P_H_SYNC + P_H_BACK - 10'd1;
    localparam logic [9:0] Y_ORIGIN = P_V_SYNC + P_V_BACK;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_wrap;
    logic       v_wrap_unused;
    axis_win_t  h_win;
    axis_win_t  v_win;
    logic       rgb_valid;
    logic       pix_req;

    // Horizontal axis: free-running, request window leads by one clock
    tft_axis_cnt #(
        .TOTAL    (P_H_TOTAL),
        .SYNC     (P_H_SYNC),
        .BACK     (P_H_BACK),
        .VALID    (P_H_VALID),
        .REQ_LEAD (10'd1)
    ) u_h_cnt (
        .clk   (clk_9m),
        .rst_n (sys_rst_n),
        .en    (1'b1),
        .cnt   (cnt_h),
        .wrap  (h_wrap),
        .win   (h_win)
    );

    // Vertical axis: steps at end of line, request window equals active
    tft_axis_cnt #(
        .TOTAL    (P_V_TOTAL),
        .SYNC     (P_V_SYNC),
        .BACK     (P_V_BACK),
        .VALID    (P_V_VALID),
        .REQ_LEAD (10'd0)
    ) u_v_cnt (
        .clk   (clk_9m),
        .rst_n (sys_rst_n),
        .en    (h_wrap),
        .cnt   (cnt_v),
        .wrap  (v_wrap_unused),
        .win   (v_win)
    );

    // Output decode from the registered counters, no extra pipeline
    always_comb begin
        rgb_valid   = h_win.valid & v_win.valid;
        pix_req     = h_win.req & v_win.req;
        hsync       = h_win.sync_act ? P_SYNC_POL : ~P_SYNC_POL;
        vsync       = v_win.sync_act ? P_SYNC_POL : ~P_SYNC_POL;
        pix_x       = pix_req ? (cnt_h - X_ORIGIN) : NO_PIX;
        pix_y       = pix_req ? (cnt_v - Y_ORIGIN) : NO_PIX;
        rgb_tft     = rgb_valid ? pix_data : BLACK;
        frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);
    end

    assign tft_de  = rgb_valid;
    assign tft_clk = clk_9m;
    assign tft_bl  = sys_rst_n;

endmodule

// File: tb/tb_tft_ctrl.sv
// Bench for tft_ctrl: a full-size instance checked over the first 100
// lines plus a mid-frame reset, and a shrunken-timing instance that runs
// whole frames and random resets. Both are compared each cycle against
// a reference computed from elapsed clocks since reset release.
module tb_tft_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b0;
  logic        rst1 = 1'b0;
  logic [15:0] pd0 = 16'h0;
  logic [15:0] pd1 = 16'h0;
  logic [9:0]  px0, py0, px1, py1;
  logic [15:0] rgb0, rgb1;
  logic        hs0, vs0, de0, tc0, bl0, fs0;
  logic        hs1, vs1, de1, tc1, bl1, fs1;

  int tests = 0;
  int fails = 0;

  tft_ctrl u_dut0 (
    .clk_9m(clk), .sys_rst_n(rst0), .pix_data(pd0), .pix_x(px0), .pix_y(py0),
    .rgb_tft(rgb0), .hsync(hs0), .vsync(vs0), .tft_de(de0), .tft_clk(tc0),
    .tft_bl(bl0), .frame_start(fs0)
  );

  tft_ctrl #(
    .P_H_SYNC(10'd3), .P_H_BACK(10'd2), .P_H_VALID(10'd8), .P_H_TOTAL(10'd15),
    .P_V_SYNC(10'd2), .P_V_BACK(10'd1), .P_V_VALID(10'd4), .P_V_TOTAL(10'd9)
  ) u_dut1 (
    .clk_9m(clk), .sys_rst_n(rst1), .pix_data(pd1), .pix_x(px1), .pix_y(py1),
    .rgb_tft(rgb1), .hsync(hs1), .vsync(vs1), .tft_de(de1), .tft_clk(tc1),
    .tft_bl(bl1), .frame_start(fs1)
  );

  // Stub pixel generators: registered column index inside the request
  // window, random junk outside it (must never reach the panel)
  always @(posedge clk) begin
    pd0 <= (px0 == 10'h3ff) ? 16'($urandom) : {6'd0, px0};
    pd1 <= (px1 == 10'h3ff) ? 16'($urandom) : {6'd0, px1};
  end

  typedef struct {
    int hs, hb, hv, ht, vs, vb, vv, vt;
  } tim_t;

  typedef struct {
    int h, v;
    bit hs, vs, de, fs;
    int px, py, rgb;
  } vec_t;

  // Reference: position derived from elapsed clocks; pixel (x,y) shows at
  // column origin+x, and is requested one clock before that
  function automatic logic [39:0] model(input tim_t c, input int t);
    int h, v, x0, y0;
    bit vin, de, req;
    logic [9:0] px, py;
    logic [15:0] rgb;
    h   = t % c.ht;
    v   = (t / c.ht) % c.vt;
    x0  = c.hs + c.hb;
    y0  = c.vs + c.vb;
    vin = (v >= y0) && (v < y0 + c.vv);
    de  = vin && (h >= x0) && (h < x0 + c.hv);
    req = vin && (h + 1 >= x0) && (h + 1 < x0 + c.hv);
    px  = req ? 10'(h + 1 - x0) : 10'h3ff;
    py  = req ? 10'(v - y0) : 10'h3ff;
    rgb = de ? 16'(h - x0) : 16'h0;
    return {(h < c.hs), (v < c.vs), de, (h == 0 && v == 0), px, py, rgb};
  endfunction

  function automatic logic [39:0] act(input int sel);
    if (sel == 0) return {hs0, vs0, de0, fs0, px0, py0, rgb0};
    return {hs1, vs1, de1, fs1, px1, py1, rgb1};
  endfunction

  task automatic chk_vec(input string name, input int t, input logic [39:0] a,
                         input logic [39:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0d got {hs,vs,de,fs,x,y,rgb}=%h expected %h", name, t, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, a, e);
    end
  endtask

  // Values that must hold while reset is asserted
  task automatic chk_reset(input int sel, input string tag);
    logic [39:0] a;
    a = act(sel);
    chk_int({tag, "_de"}, a[37], 0);
    chk_int({tag, "_pix_x"}, a[35:26], 10'h3ff);
    chk_int({tag, "_pix_y"}, a[25:16], 10'h3ff);
    chk_int({tag, "_rgb"}, a[15:0], 0);
    chk_int({tag, "_hsync"}, a[39], 1);
    chk_int({tag, "_vsync"}, a[38], 1);
    chk_int({tag, "_bl"}, (sel == 0) ? bl0 : bl1, 0);
  endtask

  initial begin
    #6_000_000;
    fails++;
    $display("FAIL watchdog time limit expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    tim_t c0, c1;
    vec_t tbl[13];
    bit   line_de[100];
    int   hs_hi, hs_lo, hs_rise, de_l11, de_l12, lines_de, first_de;
    int   t_rst;
    bit   prev_hs;

    c0 = '{41, 2, 480, 525, 10, 2, 272, 286};
    c1 = '{3, 2, 8, 15, 2, 1, 4, 9};

    //         h    v  hs vs de fs  px    py    rgb
    tbl[0]  = '{0,   0,  1, 1, 0, 1, 1023, 1023, 0};
    tbl[1]  = '{40,  0,  1, 1, 0, 0, 1023, 1023, 0};
    tbl[2]  = '{41,  0,  0, 1, 0, 0, 1023, 1023, 0};
    tbl[3]  = '{524, 9,  0, 1, 0, 0, 1023, 1023, 0};
    tbl[4]  = '{0,   10, 1, 0, 0, 0, 1023, 1023, 0};
    tbl[5]  = '{42,  11, 0, 0, 0, 0, 1023, 1023, 0};
    tbl[6]  = '{42,  12, 0, 0, 0, 0, 0,    0,    0};
    tbl[7]  = '{43,  12, 0, 0, 1, 0, 1,    0,    0};
    tbl[8]  = '{521, 12, 0, 0, 1, 0, 479,  0,    478};
    tbl[9]  = '{522, 12, 0, 0, 1, 0, 1023, 1023, 479};
    tbl[10] = '{523, 12, 0, 0, 0, 0, 1023, 1023, 0};
    tbl[11] = '{300, 50, 0, 0, 1, 0, 258,  38,   257};
    tbl[12] = '{100, 99, 0, 0, 1, 0, 58,   87,   57};

    // ---- full-size instance: reset state and first 100 lines ----
    repeat (3) @(negedge clk);
    chk_reset(0, "init_rst");
    @(negedge clk);
    rst0 = 1'b1;
    #1;
    chk_int("bl_after_release", bl0, 1);

    hs_hi = 0; hs_lo = 0; hs_rise = -1; de_l11 = 0; de_l12 = 0;
    prev_hs = 1'b1;
    foreach (line_de[i]) line_de[i] = 1'b0;
    t_rst = 100 * 525 + 300;
    for (int t = 0; t <= t_rst; t++) begin
      int h, v;
      if (t > 0) @(negedge clk);
      h = t % 525;
      v = t / 525;
      chk_vec("cycle_full", t, act(0), model(c0, t));
      foreach (tbl[i]) begin
        if (tbl[i].h == h && tbl[i].v == v)
          chk_vec("table", t, act(0),
                  {tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].fs,
                   10'(tbl[i].px), 10'(tbl[i].py), 16'(tbl[i].rgb)});
      end
      if (v == 0) begin
        if (hs0) hs_hi++; else hs_lo++;
      end
      if (hs_rise < 0 && hs0 && !prev_hs) hs_rise = t;
      prev_hs = hs0;
      if (v == 11 && de0) de_l11++;
      if (v == 12 && de0) de_l12++;
      if (v < 100 && de0) line_de[v] = 1'b1;
      if (fails > 50) break;
    end
    chk_int("hsync_high_clocks", hs_hi, 41);
    chk_int("hsync_low_clocks", hs_lo, 484);
    chk_int("hsync_period", hs_rise, 525);
    chk_int("de_clocks_line11", de_l11, 0);
    chk_int("de_clocks_line12", de_l12, 480);
    lines_de = 0;
    foreach (line_de[i]) lines_de += int'(line_de[i]);
    chk_int("de_lines_0_99", lines_de, 88);

    // ---- mid-frame reset at cnt_h=300, cnt_v=100 ----
    rst0 = 1'b0;
    #1;
    chk_reset(0, "mid_rst");
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    #1;
    first_de = -1;
    for (int t = 0; t <= 6400; t++) begin
      if (t > 0) @(negedge clk);
      chk_vec("cycle_after_rst", t, act(0), model(c0, t));
      if (first_de < 0 && de0) first_de = t;
      if (fails > 50) break;
    end
    chk_int("first_de_after_rst", first_de, 12 * 525 + 43);

    // ---- shrunken-timing instance: whole frames, random resets ----
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) begin
      int n, fs_cnt, vs_hi, de_cnt;
      n = (r < 3) ? int'($urandom_range(20, 300)) : 5 * 135;
      fs_cnt = 0; vs_hi = 0; de_cnt = 0;
      for (int t = 0; t < n; t++) begin
        if (t > 0) @(negedge clk);
        chk_vec("cycle_small", t, act(1), model(c1, t));
        if (r == 3) begin
          fs_cnt += int'(fs1);
          if (t < 135) begin
            vs_hi  += int'(vs1);
            de_cnt += int'(de1);
          end
        end
        if (fails > 50) break;
      end
      if (r < 3) begin
        rst1 = 1'b0;
        #1;
        chk_reset(1, "small_rst");
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst1 = 1'b1;
        #1;
      end else begin
        chk_int("small_frame_starts", fs_cnt, 5);
        chk_int("small_vsync_clocks", vs_hi, 30);
        chk_int("small_de_clocks", de_cnt, 32);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
